// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, response and memory-side signals
// for the shared instruction/data memory arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_addr, ls_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_addr, ls_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port memory shared by fetch and load/store.
// Load/store wins; define MEM_ARB_STARVE_GUARD_EN to bound fetch wait.
module mem_port_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic ck,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IF,
    WAIT_LS
  } state_t;

  state_t            r_state;
  logic              r_if_rvalid;
  logic              r_ls_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_ls_rdata;

  logic w_idle;
  logic w_guard_hit;
  logic w_ls_win;
  logic w_if_win;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be 1..15");
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starve_cnt;

  assign w_guard_hit = bus.if_req &&
                       (r_starve_cnt == LIMIT);

  // count ls grants taken while fetch is waiting
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_if_win || !bus.if_req) begin
      r_starve_cnt <= '0;
    end else if (w_ls_win && r_starve_cnt != LIMIT) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end
`else
  assign w_guard_hit = 1'b0;
`endif

  assign w_idle   = !rst && (r_state == IDLE);
  assign w_ls_win = w_idle && bus.ls_req &&
                    !w_guard_hit;
  assign w_if_win = w_idle && bus.if_req &&
                    !w_ls_win;

  assign bus.if_gnt    = w_if_win;
  assign bus.ls_gnt    = w_ls_win;
  assign bus.mem_en    = w_if_win || w_ls_win;
  assign bus.mem_we    = w_ls_win && bus.ls_we;
  assign bus.mem_addr  = w_ls_win ? bus.ls_addr :
                         w_if_win ? bus.if_addr :
                         '0;
  assign bus.mem_wdata = w_ls_win ? bus.ls_wdata : '0;

  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.ls_rvalid = r_ls_rvalid;
  assign bus.ls_rdata  = r_ls_rdata;
  assign bus.busy      = (r_state != IDLE);

  // sequencer: one read in flight, response registered on return
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_if_win) begin
            r_state <= WAIT_IF;
          end else if (w_ls_win && !bus.ls_we) begin
            r_state <= WAIT_LS;
          end
        end
        WAIT_IF: begin
          r_if_rdata  <= bus.mem_rdata;
          r_if_rvalid <= 1'b1;
          r_state     <= IDLE;
        end
        WAIT_LS: begin
          r_ls_rdata  <= bus.mem_rdata;
          r_ls_rvalid <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic
// checked each cycle against a cycle-level behavioural model.
module tb_mem_port_arbiter;

  localparam int AW  = 9;
  localparam int DW  = 16;
  localparam int LIM = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic ck = 1'b0;
  logic rst;
  always #5 ck = ~ck;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .ck(ck),
    .rst(rst),
    .bus(bus.slave)
  );

  function automatic logic [DW-1:0] init_word(int a);
    if (a == 3) return 16'h7200;
    return 16'(a * 257) ^ 16'h5A00;
  endfunction

  // memory: write in grant cycle, read data the cycle after
  logic [DW-1:0] mem [512];
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = init_word(i);
    bus.mem_rdata <= '0;
    forever begin
      @(posedge ck);
      if (bus.mem_en && bus.mem_we)
        mem[bus.mem_addr] = bus.mem_wdata;
      if (bus.mem_en && !bus.mem_we)
        bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DW-1:0] shadow [512];
  bit            m_wait;
  int            m_if_due, m_ls_due;
  logic [DW-1:0] m_if_pend, m_ls_pend;
  logic [DW-1:0] m_if_rdata, m_ls_rdata;
  int            m_starve;
  bit            e_if, e_ls;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    m_wait     = 1'b0;
    m_if_due   = -1;
    m_ls_due   = -1;
    m_if_rdata = '0;
    m_ls_rdata = '0;
    m_starve   = 0;
  endtask

  // compare every DUT output against the model at mid-cycle
  task automatic sample();
    bit g_hit;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    @(negedge ck);
    if (cyc == m_if_due) m_if_rdata = m_if_pend;
    if (cyc == m_ls_due) m_ls_rdata = m_ls_pend;
    if (rst) begin
      e_if = 1'b0;
      e_ls = 1'b0;
    end else begin
      g_hit = GUARD && bus.if_req && (m_starve >= LIM);
      e_ls = !m_wait && bus.ls_req && !g_hit;
      e_if = !m_wait && bus.if_req && !e_ls;
    end
    ea = e_ls ? bus.ls_addr : e_if ? bus.if_addr : '0;
    ew = e_ls ? bus.ls_wdata : '0;
    chk("if_gnt", bus.if_gnt, e_if);
    chk("ls_gnt", bus.ls_gnt, e_ls);
    chk("mem_en", bus.mem_en, e_if || e_ls);
    chk("mem_we", bus.mem_we, e_ls && bus.ls_we);
    chk("mem_addr", bus.mem_addr, ea);
    chk("mem_wdata", bus.mem_wdata, ew);
    chk("if_rvalid", bus.if_rvalid, cyc == m_if_due);
    chk("ls_rvalid", bus.ls_rvalid, cyc == m_ls_due);
    chk("if_rdata", bus.if_rdata, m_if_rdata);
    chk("ls_rdata", bus.ls_rdata, m_ls_rdata);
    chk("busy", bus.busy, m_wait);
  endtask

  // apply the granted access to the model, then move one cycle on
  task automatic advance();
    if (rst) begin
      model_clear();
    end else begin
      if (e_if) begin
        m_if_due  = cyc + 2;
        m_if_pend = shadow[bus.if_addr];
      end
      if (e_ls && bus.ls_we)
        shadow[bus.ls_addr] = bus.ls_wdata;
      if (e_ls && !bus.ls_we) begin
        m_ls_due  = cyc + 2;
        m_ls_pend = shadow[bus.ls_addr];
      end
      m_wait = e_if || (e_ls && !bus.ls_we);
      if (e_if || !bus.if_req) m_starve = 0;
      else if (e_ls && m_starve < LIM) m_starve++;
    end
    @(posedge ck);
    #1;
    cyc++;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  int n_ls, n_ls_pre;
  bit seen_if;

  initial begin
    for (int i = 0; i < 512; i++) shadow[i] = init_word(i);
    model_clear();
    e_if = 1'b0;
    e_ls = 1'b0;
    rst          = 1'b1;
    bus.if_req   = 1'b1;
    bus.if_addr  = 9'd1;
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b0;
    bus.ls_addr  = 9'd2;
    bus.ls_wdata = 16'h0;

    // reset: no grants even with both requests up
    sample();
    chk("rst_if_gnt", bus.if_gnt, 0);
    chk("rst_ls_gnt", bus.ls_gnt, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    advance();
    cycle();
    rst = 1'b0;
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    sample();
    chk("rst_busy", bus.busy, 0);
    chk("rst_if_rvalid", bus.if_rvalid, 0);
    chk("rst_ls_rdata", bus.ls_rdata, 0);
    advance();

    // fetch only from address 3
    bus.if_req  = 1'b1;
    bus.if_addr = 9'd3;
    sample();
    chk("f_gnt", bus.if_gnt, 1);
    chk("f_mem_en", bus.mem_en, 1);
    chk("f_mem_addr", bus.mem_addr, 3);
    advance();
    bus.if_req = 1'b0;
    sample();
    chk("f_busy", bus.busy, 1);
    advance();
    sample();
    chk("f_rvalid", bus.if_rvalid, 1);
    chk("f_rdata", bus.if_rdata, 16'h7200);
    advance();

    // store then load the same word
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_addr  = 9'h1F0;
    bus.ls_wdata = 16'hBEEF;
    sample();
    chk("st_gnt", bus.ls_gnt, 1);
    chk("st_mem_we", bus.mem_we, 1);
    chk("st_wdata", bus.mem_wdata, 16'hBEEF);
    advance();
    bus.ls_we = 1'b0;
    sample();
    chk("ld_gnt", bus.ls_gnt, 1);
    chk("st_no_rvalid", bus.ls_rvalid, 0);
    advance();
    bus.ls_req = 1'b0;
    cycle();
    sample();
    chk("ld_rvalid", bus.ls_rvalid, 1);
    chk("ld_rdata", bus.ls_rdata, 16'hBEEF);
    advance();

    // contention: load wins, fetch follows
    bus.if_req  = 1'b1;
    bus.if_addr = 9'd7;
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_addr = 9'd5;
    sample();
    chk("c_ls_gnt", bus.ls_gnt, 1);
    chk("c_if_wait", bus.if_gnt, 0);
    advance();
    bus.ls_req = 1'b0;
    sample();
    chk("c_no_gnt_wait", bus.if_gnt, 0);
    advance();
    sample();
    chk("c_if_gnt", bus.if_gnt, 1);
    chk("c_if_addr", bus.mem_addr, 7);
    advance();
    bus.if_req = 1'b0;
    cycle();
    cycle();

    // continuous stores against a waiting fetch
    bus.if_req  = 1'b1;
    bus.if_addr = 9'd2;
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b1;
    n_ls = 0;
    n_ls_pre = 0;
    seen_if = 1'b0;
    for (int k = 0; k < 12; k++) begin
      bus.ls_addr  = 9'(9'h100 + k);
      bus.ls_wdata = 16'(16'hA000 + k);
      sample();
      if (bus.ls_gnt) begin
        n_ls++;
        if (!seen_if) n_ls_pre++;
      end
      if (bus.if_gnt) seen_if = 1'b1;
      advance();
      if (e_if) bus.if_req = 1'b0;
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    chk("g_ls_before_if", n_ls_pre, LIM);
    chk("g_if_seen", seen_if, 1);
    chk("g_ls_total", n_ls, 10);
`else
    chk("s_ls_total", n_ls, 12);
    chk("s_if_starved", seen_if, 0);
`endif
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    cycle();
    cycle();

    // reset while a load is outstanding
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_addr = 9'h1F0;
    cycle();
    bus.ls_req = 1'b0;
    rst = 1'b1;
    model_clear();
    sample();
    chk("r_busy", bus.busy, 0);
    chk("r_ls_rdata", bus.ls_rdata, 0);
    advance();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("r_no_rvalid", bus.ls_rvalid, 0);
      advance();
    end
    bus.if_req  = 1'b1;
    bus.if_addr = 9'd3;
    sample();
    chk("r_f_gnt", bus.if_gnt, 1);
    advance();
    bus.if_req = 1'b0;
    cycle();
    sample();
    chk("r_f_rdata", bus.if_rdata, 16'h7200);
    advance();

    // fetch withdrawn while load is in flight
    bus.if_req  = 1'b1;
    bus.if_addr = 9'd4;
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_addr = 9'd5;
    sample();
    chk("w_ls_gnt", bus.ls_gnt, 1);
    advance();
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    cycle();
    sample();
    chk("w_mem_en", bus.mem_en, 0);
    chk("w_if_gnt", bus.if_gnt, 0);
    chk("w_ls_rvalid", bus.ls_rvalid, 1);
    advance();

    // randomized traffic, protocol-respecting requesters
    for (int n = 0; n < 3000; n++) begin
      cycle();
      if (bus.if_req && !e_if) begin
        if ($urandom_range(15) == 0) bus.if_req = 1'b0;
      end else begin
        bus.if_req  = 1'($urandom_range(1));
        bus.if_addr = 9'($urandom_range(15));
      end
      if (bus.ls_req && !e_ls) begin
        if ($urandom_range(15) == 0) bus.ls_req = 1'b0;
      end else begin
        bus.ls_req   = ($urandom_range(3) != 0);
        bus.ls_we    = 1'($urandom_range(1));
        bus.ls_addr  = 9'($urandom_range(15));
        bus.ls_wdata = 16'($urandom);
      end
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(299) == 0) begin
        rst = 1'b1;
        model_clear();
      end
    end
    rst = 1'b0;
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    cycle();
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
